// File: rtl/tof_pll_spi_rx_if.sv
// tof_pll_spi_rx_if: three-wire PLL programming bus (SCLK, SDIN, LE).
// The initiator drives the bus through the master modport and the receiver samples it through the slave modport.
interface tof_pll_spi_rx_if;
    logic pll_sclk;
    logic pll_sdin;
    logic pll_load;
    modport master (output pll_sclk, pll_sdin, pll_load);
    modport slave  (input  pll_sclk, pll_sdin, pll_load);
endinterface

// File: rtl/tof_pll_spi_rx.sv
// tof_pll_spi_rx: oversampling receiver for 24-bit PLL programming words with a register bank and emulated lock.
// Lock emulation is enabled by defining TOF_PLL_SPI_RX_LOCK_MODEL_EN; otherwise lock_o is tied low.
module tof_pll_spi_rx #(
    parameter logic [16:0] LOCK_DELAY = 17'd94000
) (
    input  logic                 clk200_i,
    input  logic                 rst200_n_i,
    tof_pll_spi_rx_if.slave      spi,
    output logic [23:0]          word_o,
    output logic [1:0]           addr_o,
    output logic                 word_valid_o,
    output logic                 frame_err_o,
    output logic [23:0]          reg0_o,
    output logic [23:0]          reg1_o,
    output logic [23:0]          reg2_o,
    output logic [23:0]          reg3_o,
    output logic                 lock_o
);
    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    logic [1:0]  rst_sync_q;
    logic        rst_n;
    logic [2:0]  sclk_q, load_q;
    logic [1:0]  sdin_q;
    logic        sclk_rise, le_rise;
    state_t      state_q, state_d;
    logic [23:0] shreg_q, shreg_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        err_pend_q, err_pend_d;
    logic [23:0] word_q, word_d;
    logic [1:0]  addr_q, addr_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [23:0] regs_q [4];
    logic [23:0] regs_d [4];

    // Assertion is immediate, release reaches the logic two edges later.
    always_ff @(posedge clk200_i or negedge rst200_n_i) begin
        if (!rst200_n_i) rst_sync_q <= 2'b00;
        else             rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign le_rise   = load_q[1] & ~load_q[2];

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        err_pend_d = 1'b0;
        word_d     = word_q;
        addr_d     = addr_q;
        regs_d     = regs_q;
        valid_d    = 1'b0;
        err_d      = err_pend_q;
        if (state_q == LATCH) begin
            state_d   = IDLE;
            shreg_d   = '0;
            bit_cnt_d = '0;
            if (bit_cnt_q == 5'd24) begin
                valid_d                = 1'b1;
                word_d                 = shreg_q;
                addr_d                 = shreg_q[1:0];
                regs_d[shreg_q[1:0]]   = shreg_q;
            end else begin
                err_d = 1'b1;
            end
        end else if (le_rise) begin
            // An empty frame is delayed one cycle so both strobes share the same latency.
            if (state_q == SHIFT) state_d = LATCH;
            else                  err_pend_d = 1'b1;
        end else if (sclk_rise && !load_q[1]) begin
            shreg_d   = {shreg_q[22:0], sdin_q[1]};
            bit_cnt_d = (bit_cnt_q == 5'd31) ? 5'd31 : bit_cnt_q + 5'd1;
            state_d   = SHIFT;
        end
    end

    always_ff @(posedge clk200_i or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q     <= '0;
            load_q     <= '0;
            sdin_q     <= '0;
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            err_pend_q <= 1'b0;
            word_q     <= '0;
            addr_q     <= '0;
            regs_q     <= '{default: '0};
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sclk_q     <= {sclk_q[1:0], spi.pll_sclk};
            load_q     <= {load_q[1:0], spi.pll_load};
            sdin_q     <= {sdin_q[0], spi.pll_sdin};
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            err_pend_q <= err_pend_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            regs_q     <= regs_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign word_o       = word_q;
    assign addr_o       = addr_q;
    assign word_valid_o = valid_q;
    assign frame_err_o  = err_q;
    assign reg0_o       = regs_q[0];
    assign reg1_o       = regs_q[1];
    assign reg2_o       = regs_q[2];
    assign reg3_o       = regs_q[3];

`ifdef TOF_PLL_SPI_RX_LOCK_MODEL_EN
    typedef enum logic [1:0] {UNLOCKED, COUNT, LOCKED} lock_t;

    lock_t       lock_st_q, lock_st_d;
    logic [2:0]  wr_q, wr_d;
    logic [16:0] lock_cnt_q, lock_cnt_d;
    logic        lock_q, lock_d;

    always_comb begin
        lock_st_d  = lock_st_q;
        wr_d       = wr_q;
        lock_cnt_d = lock_cnt_q;
        lock_d     = lock_q;
        if (valid_d && lock_st_q == UNLOCKED) begin
            wr_d = wr_q | {addr_d == 2'd2, addr_d == 2'd1, addr_d == 2'd0};
            if (&wr_d) begin
                lock_st_d  = COUNT;
                lock_cnt_d = '0;
            end
        end else if (valid_d && !addr_d[1]) begin
            lock_st_d  = COUNT;
            lock_cnt_d = '0;
            lock_d     = 1'b0;
        end else if (lock_st_q == COUNT) begin
            if (lock_cnt_q == LOCK_DELAY - 17'd1) begin
                lock_st_d = LOCKED;
                lock_d    = 1'b1;
            end else begin
                lock_cnt_d = lock_cnt_q + 17'd1;
            end
        end
    end

    always_ff @(posedge clk200_i or negedge rst_n) begin
        if (!rst_n) begin
            lock_st_q  <= UNLOCKED;
            wr_q       <= '0;
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
        end else begin
            lock_st_q  <= lock_st_d;
            wr_q       <= wr_d;
            lock_cnt_q <= lock_cnt_d;
            lock_q     <= lock_d;
        end
    end

    assign lock_o = lock_q;
`else
    assign lock_o = &{1'b0, LOCK_DELAY};
`endif
endmodule

// File: tb/tb_tof_pll_spi_rx.sv
// tb_tof_pll_spi_rx: directed frames with a queue-based scoreboard checking strobe kind, cycle, word and address.
module tb_tof_pll_spi_rx;
`ifdef TOF_PLL_SPI_RX_LOCK_MODEL_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    tof_pll_spi_rx_if bus();
    logic [23:0] word_o, reg0_o, reg1_o, reg2_o, reg3_o;
    logic [1:0]  addr_o;
    logic        word_valid_o, frame_err_o, lock_o;

    tof_pll_spi_rx #(.LOCK_DELAY(17'd10)) dut (
        .clk200_i     (clk),
        .rst200_n_i   (rst_n),
        .spi          (bus),
        .word_o       (word_o),
        .addr_o       (addr_o),
        .word_valid_o (word_valid_o),
        .frame_err_o  (frame_err_o),
        .reg0_o       (reg0_o),
        .reg1_o       (reg1_o),
        .reg2_o       (reg2_o),
        .reg3_o       (reg3_o),
        .lock_o       (lock_o)
    );

    typedef struct {bit is_word; logic [23:0] w; int due;} exp_t;
    exp_t        expq[$];
    logic [23:0] exp_reg [4];
    bit          exp_lock;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (word_valid_o || frame_err_o)) begin
            chk("strobe_excl", 32'(word_valid_o & frame_err_o), 32'(0));
            if (expq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_strobe: got valid=%b err=%b expected none at cycle %0d", word_valid_o, frame_err_o, cyc);
            end else begin
                e = expq.pop_front();
                chk("strobe_kind", 32'(word_valid_o), 32'(e.is_word));
                chk("strobe_cycle", 32'(cyc), 32'(e.due));
                if (e.is_word) begin
                    chk("word_o", 32'(word_o), 32'(e.w));
                    chk("addr_o", 32'(addr_o), 32'(e.w[1:0]));
                end
            end
        end
    end

    task automatic shift_bits(input logic [23:0] w, input int n);
        logic [23:0] s;
        s = w;
        for (int i = 0; i < n; i++) begin
            bus.pll_sdin = s[23];
            s = s << 1;
            repeat (4) @(negedge clk);
            bus.pll_sclk = 1'b1;
            repeat (4) @(negedge clk);
            bus.pll_sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
    endtask

    // lmode: 0 no lock check, 1 first lock, 2 relock from locked, 3 lock unaffected
    task automatic le_pulse(input bit is_word, input logic [23:0] w, input int lmode, input bit toggle);
        int c0;
        @(negedge clk);
        bus.pll_load = 1'b1;
        c0 = cyc;
        expq.push_back('{is_word, w, c0 + 4});
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (toggle) bus.pll_sclk = k[2];
            if (lmode != 0) begin
                if (k == 3) chk("lock_before", 32'(lock_o), 32'(LOCK_EN && lmode != 1));
                if (k == 4 || k == 13) chk("lock_hold", 32'(lock_o), 32'(LOCK_EN && lmode == 3));
                if (k == 14) chk("lock_rise", 32'(lock_o), 32'(LOCK_EN));
            end
        end
        bus.pll_sclk = 1'b0;
        bus.pll_load = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic check_regs();
        chk("reg0_o", 32'(reg0_o), 32'(exp_reg[0]));
        chk("reg1_o", 32'(reg1_o), 32'(exp_reg[1]));
        chk("reg2_o", 32'(reg2_o), 32'(exp_reg[2]));
        chk("reg3_o", 32'(reg3_o), 32'(exp_reg[3]));
        chk("lock_o", 32'(lock_o), 32'(exp_lock & LOCK_EN));
    endtask

    initial begin
        bus.pll_sclk = 1'b0;
        bus.pll_sdin = 1'b0;
        bus.pll_load = 1'b0;
        exp_reg = '{default: '0};
        exp_lock = 1'b0;
        #1 rst_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_valid", 32'(word_valid_o), 32'(0));
        chk("rst_err", 32'(frame_err_o), 32'(0));
        chk("rst_word", 32'(word_o), 32'(0));
        chk("rst_addr", 32'(addr_o), 32'(0));
        check_regs();
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        shift_bits(24'h34002D, 24); le_pulse(1'b1, 24'h34002D, 0, 1'b0);
        exp_reg[1] = 24'h34002D; check_regs();
        shift_bits(24'h0481A4, 23); le_pulse(1'b0, 24'h0, 0, 1'b0);
        check_regs();
        shift_bits(24'h0481A4, 24); le_pulse(1'b1, 24'h0481A4, 0, 1'b0);
        exp_reg[0] = 24'h0481A4; check_regs();
        shift_bits(24'h002C0A, 24); le_pulse(1'b1, 24'h002C0A, 1, 1'b0);
        exp_reg[2] = 24'h002C0A; exp_lock = 1'b1; check_regs();
        shift_bits(24'h0481A4, 24); le_pulse(1'b1, 24'h0481A4, 2, 1'b0);
        check_regs();
        shift_bits(24'h002C0A, 24); le_pulse(1'b1, 24'h002C0A, 3, 1'b0);
        check_regs();

        shift_bits(24'hFFFFFF, 26); le_pulse(1'b0, 24'h0, 0, 1'b0);
        check_regs();
        shift_bits(24'hABCDE7, 24); le_pulse(1'b1, 24'hABCDE7, 0, 1'b1);
        exp_reg[3] = 24'hABCDE7; check_regs();
        shift_bits(24'h123456, 24); le_pulse(1'b1, 24'h123456, 0, 1'b0);
        exp_reg[2] = 24'h123456; check_regs();
        le_pulse(1'b0, 24'h0, 0, 1'b0);
        check_regs();

        shift_bits(24'h002C0A, 12);
        rst_n = 1'b0;
        #1;
        exp_reg = '{default: '0};
        exp_lock = 1'b0;
        chk("midrst_word", 32'(word_o), 32'(0));
        chk("midrst_addr", 32'(addr_o), 32'(0));
        check_regs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        shift_bits(24'h002C0A, 24); le_pulse(1'b1, 24'h002C0A, 0, 1'b0);
        exp_reg[2] = 24'h002C0A; check_regs();

        for (int i = 0; i < 50 && expq.size() != 0; i++) @(negedge clk);
        chk("queue_drain", 32'(expq.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tof_pll_spi_rx.md
TOF_PLL_SPI_RX -- requirements
Module: tof_pll_spi_rx

Interface
REQ-001 The block SHALL have one clock, clk200_i, and an asynchronous active-low reset, rst200_n_i; both are listed first below.
REQ-002 Parameter LOCK_DELAY, default 17'd94000: clk200_i cycles from programming complete to lock_o high.
REQ-003 clk200_i  input  1  sole clock; all logic is rising-edge.
REQ-004 rst200_n_i  input  1  asynchronous active-low reset.
REQ-005 pll_sclk_i  input  1  serial clock from the initiator; asynchronous to clk200_i.
REQ-006 pll_sdin_i  input  1  serial data, MSB first; asynchronous.
REQ-007 pll_load_i  input  1  latch enable (LE); asynchronous.
REQ-008 word_o  output  24  last accepted word.
REQ-009 addr_o  output  2  control bits word_o[1:0] of the last accepted word.
REQ-010 word_valid_o  output  1  one-cycle strobe when a word is accepted.
REQ-011 frame_err_o  output  1  one-cycle strobe when LE arrives with a bit count other than 24.
REQ-012 reg0_o, reg1_o, reg2_o, reg3_o  output  24 each  register bank indexed by control bits.
REQ-013 lock_o  output  1  emulated PLL lock.

Function
REQ-014 pll_sclk_i, pll_sdin_i and pll_load_i SHALL each pass through a 2-flop synchronizer, plus one history flop for edge detection.
REQ-015 A synchronized SCLK rising edge while synchronized LE is low SHALL shift: shreg <= {shreg[22:0], sdin_sync}; bit_cnt increments and saturates at 31.
REQ-016 SCLK edges while LE is high SHALL be ignored.
REQ-017 Frame FSM states: IDLE (bit_cnt = 0), SHIFT (bit_cnt > 0), LATCH (one cycle). IDLE->SHIFT on the first shift; SHIFT->LATCH on an LE rising edge; LATCH->IDLE unconditionally.
REQ-018 An LE rising edge in IDLE SHALL pulse frame_err_o and stay in IDLE.
REQ-019 In LATCH with bit_cnt = 24: write reg[shreg[1:0]] <= shreg, word_o <= shreg, addr_o <= shreg[1:0], and pulse word_valid_o.
REQ-020 In LATCH with bit_cnt != 24 (including 25..31): pulse frame_err_o only; no register, word_o or addr_o update.
REQ-021 bit_cnt and shreg SHALL clear on LATCH exit.
REQ-022 Latency: word_valid_o/frame_err_o SHALL assert exactly 3 clk200_i cycles after the first edge that samples pll_load_i high.
REQ-023 Simultaneous synchronized SCLK rise and LE rise: LE takes priority, uses pre-shift contents, and the SCLK edge is discarded.
REQ-024 Inputs SHALL be held stable for at least 3 clk200_i cycles per level; narrower pulses are out of specification and may be lost without error.
REQ-025 word_valid_o and frame_err_o SHALL never both be high in the same cycle.

Reset
REQ-026 Asserting rst200_n_i low SHALL immediately clear: all synchronizer flops, shreg, bit_cnt, FSM (to IDLE), word_o, addr_o, reg0_o..reg3_o (all 24'h000000), word_valid_o, frame_err_o, lock_o, written flags and lock counter.
REQ-027 Reset mid-frame SHALL discard partial bits; the next frame starts from bit 0 after reset release.
REQ-028 Reset release SHALL be internally synchronized so that the first logic update occurs 2 cycles after deassertion.

Configuration
REQ-029 Macro TOF_PLL_SPI_RX_LOCK_MODEL_EN SHALL control lock emulation.
REQ-030 When defined, lock FSM: UNLOCKED until addresses 0, 1 and 2 have each been accepted since reset; then COUNT for LOCK_DELAY cycles; then LOCKED (lock_o = 1).
REQ-031 When defined, an accepted write to address 0 or 1 in COUNT or LOCKED SHALL drop lock_o in the next cycle and restart COUNT from zero; writes to address 2 or 3 and frame errors SHALL NOT affect lock.
REQ-032 When not defined, lock_o SHALL be constant 0 and no lock counter or flags are synthesized.

Verification
REQ-033 Shift 24'h34002D, pulse LE -> word_valid_o one cycle, addr_o = 2'd1, reg1_o = 24'h34002D, others 0.
REQ-034 Shift 23 bits of 24'h0481A4, pulse LE -> frame_err_o one cycle, no register change; then a full 24-bit 24'h0481A4 -> reg0_o = 24'h0481A4.
REQ-035 Macro on, LOCK_DELAY = 10: send 24'h34002D, 24'h0481A4, 24'h002C0A -> lock_o rises 10 cycles after the third word_valid_o; resend 24'h0481A4 -> lock_o falls, then rises 10 cycles later.
REQ-036 Assert reset after 12 bits of 24'h002C0A, release, send full 24'h002C0A -> reg2_o = 24'h002C0A, no frame_err_o.
REQ-037 26 SCLK pulses, then LE -> frame_err_o; SCLK pulses while LE is high -> bit_cnt unchanged.
REQ-038 Macro off: full init sequence -> lock_o stays 0; registers are written as in REQ-033..REQ-036.
